// File: rtl/muldiv_hilo_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// One product or quotient bit per cycle; the pipeline is held via Stall_out while busy.
module muldiv_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start_in,
    input  logic [2:0]       Op_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             HiLoRead_in,
    input  logic             Flush_in,
    output logic             Busy_out,
    output logic             Done_out,
    output logic             Stall_out,
    output logic [WIDTH-1:0] Hi_out,
    output logic [WIDTH-1:0] Lo_out,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         op_q;
    logic               s_a;
    logic               s_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] snap;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    logic               in_signed;
    logic               in_a_neg;
    logic               in_b_neg;
    logic [WIDTH-1:0]   in_a_abs;
    logic [WIDTH-1:0]   in_b_abs;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;
    logic               run_div;

    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   a_raw;
    logic [2*WIDTH-1:0] result;

    assign in_signed = (Op_in == OP_MULT) || (Op_in == OP_DIV) ||
                       (Op_in == OP_MADD) || (Op_in == OP_MSUB);
    assign in_a_neg  = in_signed & A_in[WIDTH-1];
    assign in_b_neg  = in_signed & B_in[WIDTH-1];
    assign in_a_abs  = in_a_neg ? -A_in : A_in;
    assign in_b_abs  = in_b_neg ? -B_in : B_in;

    // Multiply: p holds {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, p[WIDTH-1:1]};

    // Divide: p holds {remainder, dividend/quotient}; the remainder stays below the divisor.
    assign div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, b_mag};
    assign div_ge    = ~div_diff[WIDTH];
    assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
    assign run_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);

    assign prod_signed = (s_a ^ s_b) ? -p : p;
    assign a_raw       = s_a ? -a_mag : a_mag;

    always_comb begin
        result = {hi, lo};
        case (op_q)
            OP_MULT, OP_MULTU: result = prod_signed;
            OP_MADD:           result = snap + prod_signed;
            OP_MSUB:           result = snap - prod_signed;
            OP_DIV, OP_DIVU: begin
                if (b_mag == '0)
                    result = {a_raw, {WIDTH{1'b1}}};
                else
                    result = {(s_a ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH]),
                              ((s_a ^ s_b) ? -p[WIDTH-1:0] : p[WIDTH-1:0])};
            end
            default:           result = {hi, lo};
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            s_a   <= 1'b0;
            s_b   <= 1'b0;
            a_mag <= '0;
            b_mag <= '0;
            p     <= '0;
            snap  <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start_in && !Flush_in) begin
                        if (Op_in == OP_MTHI) begin
                            hi <= A_in;
                        end else if (Op_in == OP_MTLO) begin
                            lo <= A_in;
                        end else begin
                            op_q  <= Op_in;
                            s_a   <= in_a_neg;
                            s_b   <= in_b_neg;
                            a_mag <= in_a_abs;
                            b_mag <= in_b_abs;
                            snap  <= {hi, lo};
                            p     <= (Op_in == OP_DIV || Op_in == OP_DIVU) ?
                                     {{WIDTH{1'b0}}, in_a_abs} : {{WIDTH{1'b0}}, in_b_abs};
                            cnt   <= '0;
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (Flush_in) begin
                        state <= ST_IDLE;
                    end else begin
                        p   <= run_div ? div_next : mul_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH-1))
                            state <= ST_WB;
                    end
                end
                ST_WB: begin
                    state <= ST_IDLE;
                    if (!Flush_in) begin
                        hi <= result[2*WIDTH-1:WIDTH];
                        lo <= result[WIDTH-1:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy_out  = (state != ST_IDLE);
    assign Done_out  = (state == ST_WB);
    assign Stall_out = Busy_out & (Start_in | HiLoRead_in);
    assign Hi_out    = hi;
    assign Lo_out    = lo;
    assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed cases with literal results, then random traffic
// compared every cycle against an arithmetic model of the unit.
module tb_muldiv_hilo_unit;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Start_in = 1'b0;
    logic [2:0]    Op_in = '0;
    logic [W-1:0]  A_in = '0;
    logic [W-1:0]  B_in = '0;
    logic          HiLoRead_in = 1'b0;
    logic          Flush_in = 1'b0;
    logic          Busy_out;
    logic          Done_out;
    logic          Stall_out;
    logic [W-1:0]  Hi_out;
    logic [W-1:0]  Lo_out;
    logic [1:0]    dbg_state;

    muldiv_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .Clk(Clk), .Rst(Rst), .Start_in(Start_in), .Op_in(Op_in),
        .A_in(A_in), .B_in(B_in), .HiLoRead_in(HiLoRead_in), .Flush_in(Flush_in),
        .Busy_out(Busy_out), .Done_out(Done_out), .Stall_out(Stall_out),
        .Hi_out(Hi_out), .Lo_out(Lo_out), .dbg_state(dbg_state)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from the arithmetic definition.
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [W-1:0] a,
                                                 input logic [W-1:0] b, input logic [63:0] hilo);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = hilo;
        case (op)
            3'd0: r = 64'(sa * sb);
            3'd1: r = {32'b0, a} * {32'b0, b};
            3'd2: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            3'd3: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            3'd4: r = hilo + 64'(sa * sb);
            3'd5: r = hilo - 64'(sa * sb);
            default: r = hilo;
        endcase
        return r;
    endfunction

    // Cycle-level model: pending result plus a countdown to the write-back cycle.
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = '0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always @(posedge Clk) begin
        if (!Rst) begin
            m_busy = 1'b0;
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_busy) begin
            if (Flush_in) begin
                m_busy = 1'b0;
            end else if (m_left == 1) begin
                m_hi   = m_res[63:32];
                m_lo   = m_res[31:0];
                m_busy = 1'b0;
            end else begin
                m_left--;
            end
        end else if (Start_in && !Flush_in) begin
            if (Op_in == 3'd6) m_hi = A_in;
            else if (Op_in == 3'd7) m_lo = A_in;
            else begin
                m_res  = model_result(Op_in, A_in, B_in, {m_hi, m_lo});
                m_busy = 1'b1;
                m_left = W + 1;
            end
        end
    end

    always @(negedge Clk) begin
        if (check_en) begin
            chk("cyc_hi", 64'(Hi_out), 64'(m_hi));
            chk("cyc_lo", 64'(Lo_out), 64'(m_lo));
            chk("cyc_busy", 64'(Busy_out), 64'(m_busy));
            chk("cyc_done", 64'(Done_out), 64'(m_busy && m_left == 1));
            chk("cyc_stall", 64'(Stall_out), 64'(m_busy && (Start_in || HiLoRead_in)));
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    int busy_cnt;
    int done_at;

    task automatic wait_idle();
        int n;
        n = 0;
        busy_cnt = 0;
        done_at = 0;
        while (Busy_out === 1'b1 && n < 60) begin
            n++;
            busy_cnt++;
            if (Done_out === 1'b1) done_at = busy_cnt;
            tick();
        end
        if (n >= 60) chk("op_timeout", 64'(n), 64'(0));
    endtask

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Op_in = op;
        A_in = a;
        B_in = b;
        Start_in = 1'b1;
        tick();
        Start_in = 1'b0;
        wait_idle();
    endtask

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        Rst = 1'b0;
        Start_in = 1'b1;
        Op_in = 3'd6;
        A_in = 32'hA5A5A5A5;
        B_in = 32'h12345678;
        Flush_in = 1'b1;
        HiLoRead_in = 1'b1;
        tick();
        check_en = 1'b1;
        tick();
        chk("rst_hi", 64'(Hi_out), 64'h0);
        chk("rst_lo", 64'(Lo_out), 64'h0);
        chk("rst_busy", 64'(Busy_out), 64'h0);
        Rst = 1'b1;
        Start_in = 1'b0;
        Flush_in = 1'b0;
        HiLoRead_in = 1'b0;
        tick();

        run_op(3'd0, 32'hFFFFFFFF, 32'h2);
        chk("mult_busy_cycles", 64'(busy_cnt), 64'd33);
        chk("mult_done_cycle", 64'(done_at), 64'd33);
        chk("mult_hi", 64'(Hi_out), 64'hFFFFFFFF);
        chk("mult_lo", 64'(Lo_out), 64'hFFFFFFFE);
        run_op(3'd1, 32'hFFFFFFFF, 32'h2);
        chk("multu_hi", 64'(Hi_out), 64'h1);
        chk("multu_lo", 64'(Lo_out), 64'hFFFFFFFE);

        run_op(3'd2, 32'hFFFFFFF9, 32'h2);
        chk("div_lo", 64'(Lo_out), 64'hFFFFFFFD);
        chk("div_hi", 64'(Hi_out), 64'hFFFFFFFF);
        run_op(3'd3, 32'd100, 32'd0);
        chk("divu0_lo", 64'(Lo_out), 64'hFFFFFFFF);
        chk("divu0_hi", 64'(Hi_out), 64'h64);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        chk("divmin_lo", 64'(Lo_out), 64'h80000000);
        chk("divmin_hi", 64'(Hi_out), 64'h0);

        run_op(3'd6, 32'h5, 32'h0);
        chk("mthi_busy", 64'(Busy_out), 64'h0);
        run_op(3'd7, 32'hFFFFFFFF, 32'h0);
        run_op(3'd4, 32'h1, 32'h1);
        chk("madd_hi", 64'(Hi_out), 64'h6);
        chk("madd_lo", 64'(Lo_out), 64'h0);
        run_op(3'd5, 32'h1, 32'h1);
        chk("msub_hi", 64'(Hi_out), 64'h5);
        chk("msub_lo", 64'(Lo_out), 64'hFFFFFFFF);

        Op_in = 3'd1; A_in = 32'd3; B_in = 32'd4; Start_in = 1'b1;
        tick();
        Start_in = 1'b0;
        repeat (3) tick();
        HiLoRead_in = 1'b1;
        #1 chk("stall_read", 64'(Stall_out), 64'h1);
        tick();
        HiLoRead_in = 1'b0;
        Start_in = 1'b1; Op_in = 3'd6; A_in = 32'hDEAD;
        #1 chk("stall_start", 64'(Stall_out), 64'h1);
        tick();
        Start_in = 1'b0;
        chk("stall_hi_held", 64'(Hi_out), 64'h5);
        wait_idle();
        chk("stall_res_hi", 64'(Hi_out), 64'h0);
        chk("stall_res_lo", 64'(Lo_out), 64'hC);

        Op_in = 3'd0; A_in = 32'd7; B_in = 32'd9; Start_in = 1'b1;
        tick();
        Start_in = 1'b0;
        repeat (9) tick();
        Flush_in = 1'b1;
        tick();
        Flush_in = 1'b0;
        chk("flush_busy", 64'(Busy_out), 64'h0);
        chk("flush_hi", 64'(Hi_out), 64'h0);
        chk("flush_lo", 64'(Lo_out), 64'hC);
        Op_in = 3'd1; A_in = 32'd2; B_in = 32'd3; Start_in = 1'b1;
        tick();
        Start_in = 1'b0;
        chk("flush_restart_busy", 64'(Busy_out), 64'h1);
        wait_idle();
        chk("flush_restart_lo", 64'(Lo_out), 64'h6);

        Op_in = 3'd3; A_in = 32'd50; B_in = 32'd7; Start_in = 1'b1;
        tick();
        Start_in = 1'b0;
        repeat (5) tick();
        Rst = 1'b0;
        tick();
        Rst = 1'b1;
        chk("rst_run_busy", 64'(Busy_out), 64'h0);
        chk("rst_run_hi", 64'(Hi_out), 64'h0);
        chk("rst_run_lo", 64'(Lo_out), 64'h0);

        for (int i = 0; i < 6000; i++) begin
            Rst         = ($urandom_range(0, 299) != 0);
            Start_in    = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            Op_in       = 3'($urandom_range(0, 7));
            A_in        = rand_operand();
            B_in        = rand_operand();
            Flush_in    = m_busy ? ($urandom_range(0, 63) == 0) : ($urandom_range(0, 7) == 0);
            HiLoRead_in = ($urandom_range(0, 3) == 0);
            tick();
        end

        Rst = 1'b1;
        Start_in = 1'b0;
        Flush_in = 1'b0;
        HiLoRead_in = 1'b0;
        wait_idle();
        tick();
        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Parametrised iterative multiply/divide unit with an architectural HI/LO register pair.
- Replaces the single-cycle HI/LO path in the execution stage.
- Sits beside the EX-stage ALU and takes the same ALU operands.
- Supports signed/unsigned multiply, signed/unsigned divide, multiply-accumulate/subtract, and MTHI/MTLO.
- Drives a stall request so the pipeline holds while a long operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Rst  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- Start_in  input  1  request to launch the operation on Op_in.
- Op_in  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- A_in  input  WIDTH  operand A (Rs); dividend; source for MTHI/MTLO.
- B_in  input  WIDTH  operand B (Rt); divisor.
- HiLoRead_in  input  1  an MFHI/MFLO is in EX this cycle.
- Flush_in  input  1  abort the in-flight operation (wrong path).
- Busy_out  output  1  unit is not IDLE.
- Done_out  output  1  one-cycle pulse in the write-back cycle.
- Stall_out  output  1  pipeline hold request.
- Hi_out  output  WIDTH  current HI register.
- Lo_out  output  WIDTH  current LO register.

Behaviour:
- Reset (Rst==0 at a rising edge): state=IDLE, HI=0, LO=0, counter=0, all internal datapath registers=0. Busy_out=0, Done_out=0, Stall_out=0.
- Reset overrides everything, including an operation in mid-run.
- States: IDLE, RUN, WB.
- Acceptance: Start_in==1 in IDLE with Flush_in==0. Start_in outside IDLE is ignored; the pipeline holds it via Stall_out.
- Flush_in==1 in IDLE blocks acceptance.
- MTHI/MTLO: at the accept edge, A_in is written into HI or LO. State stays IDLE, Busy_out stays 0, no Done_out pulse.
- MULT/DIV family, accept edge: latch operands and go to RUN with counter=0.
  - Signed ops (MULT, DIV, MADD, MSUB) latch the operand magnitudes plus their sign bits.
  - MADD/MSUB also latch the HI:LO snapshot.
- RUN: exactly WIDTH cycles, one bit per cycle.
  - Multiply: shift-add on the 2*WIDTH product.
  - Divide: restoring, one quotient bit per cycle.
  - counter==WIDTH-1 -> WB.
- WB, one cycle: Done_out=1 and the result is formed; HI/LO are written at the edge ending WB; state returns to IDLE.
- Latency: Done_out is high in cycle WIDTH+1 after the accept edge. Hi_out/Lo_out show the new value in cycle WIDTH+2.
- Back-to-back: a new Start_in may be accepted in the first IDLE cycle after WB.
- Result rules:
  - MULT/MULTU: {HI,LO} = full 2*WIDTH product. For signed ops the product is negated when sign(A) XOR sign(B) is 1.
  - MADD/MSUB: {HI,LO} = snapshot +/- signed product, modulo 2^(2*WIDTH).
  - DIV/DIVU: LO = quotient, HI = remainder. For signed ops, quotient sign = sA XOR sB and remainder sign = sA (truncating division).
  - Signed most-negative / -1: LO = 2^(WIDTH-1) (wraps), HI = 0.
  - Divide by zero (signed or unsigned): LO = all ones, HI = A_in as latched. No exception is raised.
- Stall_out = Busy_out AND (Start_in OR HiLoRead_in). It is combinational, with no extra cycle.
- Hi_out/Lo_out always reflect the architectural registers; they never show an in-progress partial result.
- Flush_in==1 in RUN or WB: return to IDLE at that edge. HI/LO are unchanged, including a flush during WB. No Done_out pulse occurs after the flush edge.
- Simultaneous Flush_in and Rst==0: reset wins.

Test Plan:
- Reset: Rst=0 for 2 cycles with garbage on the inputs -> Hi_out=Lo_out=0, Busy_out=0. Assert Rst=0 during RUN -> IDLE next cycle, HI/LO=0.
- MULT, A=0xFFFFFFFF, B=0x00000002 (WIDTH=32) -> Busy_out high 33 cycles, Done_out in cycle 33, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV, A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU, A=100, B=0 -> LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x5, MTLO 0xFFFFFFFF, then MADD 1*1 -> HI=0x6, LO=0. Then MSUB 1*1 -> HI=0x5, LO=0xFFFFFFFF.
- During RUN: HiLoRead_in=1 -> Stall_out=1 that cycle; Start_in=1 -> Stall_out=1 and the request is not accepted. Hi_out is unchanged until the cycle after WB.
- Flush: Flush_in=1 at RUN cycle 10 of a MULT -> IDLE next cycle, no Done_out pulse, HI/LO keep their prior values. An immediate new Start_in in the following cycle is accepted.
